spi_ram_sched: RTL and testbench

SPI_RAM_SCHED -- requirements
Module: spi_ram_sched

---
 rtl/spi_ram_sched.sv | 173 +++++++++++++++++
 tb/tb_spi_ram_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_sched.sv
// SPI slave frame decoder and scheduler for a single-port byte RAM shared with a local port.
// Define SPI_STATUS_CMD_EN to enable command 0x05 (status byte readback).
module spi_ram_sched #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
  input  logic              clk_25m,
  input  logic              rst_n,
  input  logic              cs_start,
  input  logic              cs_end,
  input  logic              spi_rx_en,
  input  logic [7:0]        receive_byte,
  input  logic              spi_tx_en,
  output logic [7:0]        send_byte,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [7:0]        ram_rdata,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [7:0]        loc_wdata,
  output logic              loc_gnt,
  output logic              loc_rvalid,
  output logic [7:0]        loc_rdata,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR_H, S_ADDR_L,
    S_WRITE, S_READ, S_IGNORE, S_STAT
  } state_t;

  state_t            r_state, w_nx;
  logic [7:0]        r_addr_h;
  logic              r_is_wr;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_re_spi;
  logic              r_spi_rd_d;
  logic [7:0]        r_loc_rdata;

  logic [ADDR_W-1:0] w_addr, w_base;
  logic w_is_wr, w_is_rd;
  logic w_cmd_ld, w_ah_ld, w_al_ld;
  logic w_spi_we, w_spi_re, w_bad;
`ifdef SPI_STATUS_CMD_EN
  logic w_is_st, w_stat_ld;
  assign w_is_st = receive_byte == 8'h05;
`endif

  assign w_is_wr = receive_byte == 8'h02;
  assign w_is_rd = receive_byte == 8'h03;
  assign w_addr  = ADDR_W'({r_addr_h, receive_byte});
  // Read entry uses the freshly received address, not the stale pointer
  assign w_base  = w_al_ld ? w_addr : r_ptr;
  assign loc_rdata = loc_rvalid ? ram_rdata : r_loc_rdata;

  always_comb begin
    w_nx     = r_state;
    w_cmd_ld = 1'b0;
    w_ah_ld  = 1'b0;
    w_al_ld  = 1'b0;
    w_spi_we = 1'b0;
    w_spi_re = 1'b0;
    w_bad    = 1'b0;
`ifdef SPI_STATUS_CMD_EN
    w_stat_ld = 1'b0;
`endif
    if (cs_start) begin
      w_nx = S_CMD;
    end else if (cs_end) begin
      w_nx = S_IDLE;
    end else begin
      unique case (r_state)
        S_CMD: if (spi_rx_en) begin
          w_cmd_ld = 1'b1;
          unique case (1'b1)
            w_is_wr, w_is_rd: w_nx = S_ADDR_H;
`ifdef SPI_STATUS_CMD_EN
            w_is_st: begin
              w_nx      = S_STAT;
              w_stat_ld = 1'b1;
            end
`endif
            default: begin
              w_nx  = S_IGNORE;
              w_bad = 1'b1;
            end
          endcase
        end
        S_ADDR_H: if (spi_rx_en) begin
          w_ah_ld = 1'b1;
          w_nx    = S_ADDR_L;
        end
        S_ADDR_L: if (spi_rx_en) begin
          w_al_ld  = 1'b1;
          w_nx     = r_is_wr ? S_WRITE : S_READ;
          w_spi_re = ~r_is_wr;
        end
        S_WRITE: w_spi_we = spi_rx_en;
        S_READ:  w_spi_re = spi_tx_en;
`ifdef SPI_STATUS_CMD_EN
        S_STAT:  w_stat_ld = spi_tx_en;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_25m) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nx;
  end

  always_ff @(posedge clk_25m) begin
    if (!rst_n) begin
      r_addr_h    <= '0;
      r_is_wr     <= 1'b0;
      r_ptr       <= '0;
      r_re_spi    <= 1'b0;
      r_spi_rd_d  <= 1'b0;
      r_loc_rdata <= '0;
      send_byte   <= FILL_BYTE;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_we      <= 1'b0;
      ram_re      <= 1'b0;
      loc_gnt     <= 1'b0;
      loc_rvalid  <= 1'b0;
      err         <= 1'b0;
    end else begin
      ram_we     <= 1'b0;
      ram_re     <= 1'b0;
      loc_gnt    <= 1'b0;
      r_re_spi   <= w_spi_re;
      r_spi_rd_d <= ram_re & r_re_spi;
      loc_rvalid <= ram_re & ~r_re_spi;
      if (loc_rvalid) r_loc_rdata <= ram_rdata;
      if (cs_start)   err <= 1'b0;
      else if (w_bad) err <= 1'b1;
      if (w_cmd_ld) r_is_wr  <= w_is_wr;
      if (w_ah_ld)  r_addr_h <= receive_byte;
      if (w_al_ld)  r_ptr    <= w_addr;
      // SPI never stalls, so it owns the port; local waits one slot
      if (w_spi_we | w_spi_re) begin
        ram_we   <= w_spi_we;
        ram_re   <= w_spi_re;
        ram_addr <= w_base;
        r_ptr    <= w_base + ADDR_W'(1);
        if (w_spi_we) ram_wdata <= receive_byte;
      end else if (loc_req && !loc_gnt) begin
        loc_gnt  <= 1'b1;
        ram_we   <= loc_we;
        ram_re   <= ~loc_we;
        ram_addr <= loc_addr;
        if (loc_we) ram_wdata <= loc_wdata;
      end
      if (w_nx == S_READ) begin
        if (r_spi_rd_d) send_byte <= ram_rdata;
      end
`ifdef SPI_STATUS_CMD_EN
      else if (w_nx == S_STAT) begin
        if (w_stat_ld) send_byte <= {6'b0, loc_req, err};
      end
`endif
      else begin
        send_byte <= FILL_BYTE;
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_sched.sv
// Directed bench for spi_ram_sched: vector table of SPI events plus
// hand sequences for arbitration, local access and reset.
module tb_spi_ram_sched;

  logic       clk_25m = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_start = 1'b0, cs_end = 1'b0;
  logic       spi_rx_en = 1'b0, spi_tx_en = 1'b0;
  logic [7:0] receive_byte = 8'h00;
  logic [7:0] send_byte;
  logic [9:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we, ram_re;
  logic [7:0] ram_rdata = 8'h00;
  logic       loc_req = 1'b0, loc_we = 1'b0;
  logic [9:0] loc_addr = 10'h0;
  logic [7:0] loc_wdata = 8'h00;
  logic       loc_gnt, loc_rvalid;
  logic [7:0] loc_rdata;
  logic       err;

  int errs = 0;
  int total = 0;

  logic [7:0] mem [0:1023] = '{default: 8'h00};

  always #20 clk_25m = ~clk_25m;

  always @(posedge clk_25m) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  spi_ram_sched #(.ADDR_W(10), .FILL_BYTE(8'hFF)) dut (
    .clk_25m(clk_25m), .rst_n(rst_n),
    .cs_start(cs_start), .cs_end(cs_end),
    .spi_rx_en(spi_rx_en), .receive_byte(receive_byte),
    .spi_tx_en(spi_tx_en), .send_byte(send_byte),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata),
    .loc_req(loc_req), .loc_we(loc_we),
    .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_gnt(loc_gnt), .loc_rvalid(loc_rvalid),
    .loc_rdata(loc_rdata), .err(err)
  );

  typedef struct {
    logic       cs_s, cs_e, rx, tx;
    logic [7:0] b;
    int         acc;
    logic [9:0] addr;
    logic [7:0] wd;
    logic [7:0] snd;
    logic       er;
  } vec_t;

  localparam int K_S = 0, K_E = 1, K_RX = 2;
  localparam int K_TX = 3, K_SRX = 4, K_ERX = 5;

`ifdef SPI_STATUS_CMD_EN
  localparam logic [7:0] ST_SND = 8'h00;
  localparam logic       ST_ER  = 1'b0;
`else
  localparam logic [7:0] ST_SND = 8'hFF;
  localparam logic       ST_ER  = 1'b1;
`endif

  function automatic vec_t ev(input int k, input logic [7:0] b,
                              input int acc, input logic [9:0] a,
                              input logic [7:0] wd,
                              input logic [7:0] snd, input logic er);
    vec_t v;
    v.cs_s = (k == K_S) || (k == K_SRX);
    v.cs_e = (k == K_E) || (k == K_ERX);
    v.rx   = (k == K_RX) || (k == K_SRX) || (k == K_ERX);
    v.tx   = (k == K_TX);
    v.b = b; v.acc = acc; v.addr = a; v.wd = wd;
    v.snd = snd; v.er = er;
    return v;
  endfunction

  task automatic step();
    @(posedge clk_25m);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string nm);
    chk(nm, {send_byte, ram_we, ram_re, loc_gnt, loc_rvalid, err,
             ram_addr, ram_wdata, loc_rdata},
        {8'hFF, 5'b0, 10'h0, 8'h0, 8'h0});
  endtask

  // One SPI event pulse, then 3 quiet cycles (minimum pulse spacing)
  task automatic apply_vec(input vec_t v, input string nm);
    int n = 0;
    int kind = 0;
    logic [9:0] a = '0;
    logic [7:0] d = '0;
    cs_start = v.cs_s; cs_end = v.cs_e;
    spi_rx_en = v.rx; spi_tx_en = v.tx;
    receive_byte = v.b;
    for (int i = 0; i < 4; i++) begin
      step();
      cs_start = 0; cs_end = 0;
      spi_rx_en = 0; spi_tx_en = 0;
      if (ram_we || ram_re) begin
        n++;
        if (n == 1) begin
          kind = ram_we ? 1 : 2;
          a = ram_addr;
          d = ram_wdata;
        end
      end
    end
    chk({nm, "_acc"}, {n[7:0], kind[7:0]},
        {(v.acc != 0) ? 8'd1 : 8'd0, v.acc[7:0]});
    if (v.acc == 1) chk({nm, "_wr"}, {a, d}, {v.addr, v.wd});
    if (v.acc == 2) chk({nm, "_rd"}, a, v.addr);
    chk({nm, "_snd"}, send_byte, v.snd);
    chk({nm, "_err"}, err, v.er);
  endtask

  vec_t tbl[$];

  initial begin
    int got;
    tbl.push_back(ev(K_S,   8'h00, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h02, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h00, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h10, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'hAA, 1, 10'h010, 8'hAA, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'hBB, 1, 10'h011, 8'hBB, 8'hFF, 0));
    tbl.push_back(ev(K_E,   8'h00, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_S,   8'h00, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h03, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h00, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h10, 2, 10'h010, 0, 8'hAA, 0));
    tbl.push_back(ev(K_TX,  8'h00, 2, 10'h011, 0, 8'hBB, 0));
    tbl.push_back(ev(K_TX,  8'h00, 2, 10'h012, 0, 8'h00, 0));
    tbl.push_back(ev(K_E,   8'h00, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_S,   8'h00, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h02, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'hFF, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'hFF, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h11, 1, 10'h3FF, 8'h11, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h22, 1, 10'h000, 8'h22, 8'hFF, 0));
    tbl.push_back(ev(K_E,   8'h00, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_S,   8'h00, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h03, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'hFF, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'hFF, 2, 10'h3FF, 0, 8'h11, 0));
    tbl.push_back(ev(K_TX,  8'h00, 2, 10'h000, 0, 8'h22, 0));
    tbl.push_back(ev(K_E,   8'h00, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_S,   8'h00, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h7E, 0, 0, 0, 8'hFF, 1));
    tbl.push_back(ev(K_RX,  8'h00, 0, 0, 0, 8'hFF, 1));
    tbl.push_back(ev(K_TX,  8'h00, 0, 0, 0, 8'hFF, 1));
    tbl.push_back(ev(K_E,   8'h00, 0, 0, 0, 8'hFF, 1));
    tbl.push_back(ev(K_S,   8'h00, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h05, 0, 0, 0, ST_SND, ST_ER));
    tbl.push_back(ev(K_E,   8'h00, 0, 0, 0, 8'hFF, ST_ER));
    tbl.push_back(ev(K_S,   8'h00, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h02, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h00, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h20, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_ERX, 8'h55, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_SRX, 8'h02, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h03, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h00, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h10, 2, 10'h010, 0, 8'hAA, 0));
    tbl.push_back(ev(K_E,   8'h00, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_S,   8'h00, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h02, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h00, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_E,   8'h00, 0, 0, 0, 8'hFF, 0));
    tbl.push_back(ev(K_RX,  8'h99, 0, 0, 0, 8'hFF, 0));

    rst_n = 1'b0;
    repeat (3) step();
    check_reset("rst_init");
    rst_n = 1'b1;
    step();

    foreach (tbl[i]) apply_vec(tbl[i], $sformatf("v%0d", i));

    // Local read collides with an SPI write byte
    apply_vec(ev(K_S,  8'h00, 0, 0, 0, 8'hFF, 0), "arb_s");
    apply_vec(ev(K_RX, 8'h02, 0, 0, 0, 8'hFF, 0), "arb_c");
    apply_vec(ev(K_RX, 8'h00, 0, 0, 0, 8'hFF, 0), "arb_h");
    apply_vec(ev(K_RX, 8'h20, 0, 0, 0, 8'hFF, 0), "arb_l");
    spi_rx_en = 1; receive_byte = 8'hCC;
    loc_req = 1; loc_we = 0; loc_addr = 10'h011;
    step();
    spi_rx_en = 0;
    chk("arb_spi_first", {ram_we, loc_gnt, ram_addr, ram_wdata},
        {1'b1, 1'b0, 10'h020, 8'hCC});
    got = 0;
    for (int i = 0; i < 2 && got == 0; i++) begin
      step();
      if (loc_gnt) begin
        got = 1;
        chk("arb_gnt_cmd", {ram_re, ram_we, ram_addr},
            {1'b1, 1'b0, 10'h011});
        loc_req = 0;
      end
    end
    loc_req = 0;
    chk("arb_gnt_bound", got, 1);
    step();
    chk("arb_rvalid", {loc_rvalid, loc_rdata}, {1'b1, 8'hBB});
    step();
    chk("arb_rdata_hold", {loc_rvalid, loc_rdata}, {1'b0, 8'hBB});
    apply_vec(ev(K_E, 8'h00, 0, 0, 0, 8'hFF, 0), "arb_e");

    // Local write while SPI idle, then SPI readback
    loc_req = 1; loc_we = 1; loc_addr = 10'h100; loc_wdata = 8'h5A;
    step();
    chk("loc_wr", {loc_gnt, ram_we, ram_re, ram_addr, ram_wdata},
        {1'b1, 1'b1, 1'b0, 10'h100, 8'h5A});
    loc_req = 0; loc_we = 0;
    step();
    chk("loc_one_gnt", {loc_gnt, ram_we}, 2'b00);
    apply_vec(ev(K_S,  8'h00, 0, 0, 0, 8'hFF, 0), "lrb_s");
    apply_vec(ev(K_RX, 8'h03, 0, 0, 0, 8'hFF, 0), "lrb_c");
    apply_vec(ev(K_RX, 8'h01, 0, 0, 0, 8'hFF, 0), "lrb_h");
    apply_vec(ev(K_RX, 8'h00, 2, 10'h100, 0, 8'h5A, 0), "lrb_l");
    apply_vec(ev(K_E,  8'h00, 0, 0, 0, 8'hFF, 0), "lrb_e");

    // Reset clears a sticky error
    apply_vec(ev(K_S,  8'h00, 0, 0, 0, 8'hFF, 0), "re_s");
    apply_vec(ev(K_RX, 8'h7E, 0, 0, 0, 8'hFF, 1), "re_c");
    rst_n = 0;
    step();
    rst_n = 1;
    check_reset("rst_ign");

    // Reset lands on a data byte mid-write
    apply_vec(ev(K_S,  8'h00, 0, 0, 0, 8'hFF, 0), "rw_s");
    apply_vec(ev(K_RX, 8'h02, 0, 0, 0, 8'hFF, 0), "rw_c");
    apply_vec(ev(K_RX, 8'h00, 0, 0, 0, 8'hFF, 0), "rw_h");
    apply_vec(ev(K_RX, 8'h30, 0, 0, 0, 8'hFF, 0), "rw_l");
    rst_n = 0; spi_rx_en = 1; receive_byte = 8'h77;
    step();
    rst_n = 1; spi_rx_en = 0;
    check_reset("rst_wr");
    apply_vec(ev(K_RX, 8'h88, 0, 0, 0, 8'hFF, 0), "rw_idle");
    apply_vec(ev(K_S,  8'h00, 0, 0, 0, 8'hFF, 0), "nf_s");
    apply_vec(ev(K_RX, 8'h02, 0, 0, 0, 8'hFF, 0), "nf_c");
    apply_vec(ev(K_RX, 8'h00, 0, 0, 0, 8'hFF, 0), "nf_h");
    apply_vec(ev(K_RX, 8'h40, 0, 0, 0, 8'hFF, 0), "nf_l");
    apply_vec(ev(K_RX, 8'h99, 1, 10'h040, 8'h99, 8'hFF, 0), "nf_d");
    apply_vec(ev(K_E,  8'h00, 0, 0, 0, 8'hFF, 0), "nf_e");

    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end

endmodule
